ntt_bf_sched: RTL

Read/write scheduler for the 4-bank, 2-butterfly NTT datapath. It walks every Cooley-Tukey stage of an N-point transform and issues per-bank read addresses plus the `sel_a_*` routing codes consumed by `network_bf_in`. It also issues twiddle indices and, after a fixed butterfly latency, the matching write-back addresses and `sel_b_*` codes. It sits between the top-level NTT control (start/done) and the coefficient banks.

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/sub_delay_line.sv | 26 ++
 rtl/ntt_bf_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly scheduler: defaults, butterfly
// role codes, scheduler states and the coefficient-index to bank/address map.
package ntt_pkg;

  localparam int LOG_N_DEF  = 8;
  localparam int BF_LAT_DEF = 4;

  localparam logic [1:0] ROLE_U0 = 2'd0;
  localparam logic [1:0] ROLE_V0 = 2'd1;
  localparam logic [1:0] ROLE_U1 = 2'd2;
  localparam logic [1:0] ROLE_V1 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Upper-bit parity splits u/v pairs, the LSB splits the two butterflies.
  function automatic logic [1:0] bank_of(input logic [15:0] idx);
    return {^idx[15:1], idx[0]};
  endfunction

  function automatic logic [15:0] addr_of(input logic [15:0] idx);
    return idx >> 2;
  endfunction

endpackage

// File: rtl/sub_delay_line.sv
// Fixed-depth shift register with synchronous clear; used to replay read
// issues as write-backs a constant number of cycles later.
module sub_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/ntt_bf_sched.sv
// Read/write scheduler for a 4-bank, 2-butterfly in-place NTT: walks all
// Cooley-Tukey stages, issuing bank addresses, routing codes and twiddles.
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int LOG_N  = LOG_N_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG_N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG_N-3:0]         rd_addr_0,
  output logic [LOG_N-3:0]         rd_addr_1,
  output logic [LOG_N-3:0]         rd_addr_2,
  output logic [LOG_N-3:0]         rd_addr_3,
  output logic [1:0]               sel_a_0,
  output logic [1:0]               sel_a_1,
  output logic [1:0]               sel_a_2,
  output logic [1:0]               sel_a_3,
  output logic [LOG_N-1:0]         tw_idx_0,
  output logic [LOG_N-1:0]         tw_idx_1,
  output logic                     wr_en,
  output logic [LOG_N-3:0]         wr_addr_0,
  output logic [LOG_N-3:0]         wr_addr_1,
  output logic [LOG_N-3:0]         wr_addr_2,
  output logic [LOG_N-3:0]         wr_addr_3,
  output logic [1:0]               sel_b_0,
  output logic [1:0]               sel_b_1,
  output logic [1:0]               sel_b_2,
  output logic [1:0]               sel_b_3
);

  localparam int AW = LOG_N - 2;
  localparam int KW = LOG_N - 1;
  localparam int SW = $clog2(LOG_N);
  localparam int DW = $clog2(BF_LAT + 1);
  localparam int PW = 1 + 4 * AW + 8;

  localparam logic [AW-1:0] C_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

  state_t        state, state_nx;
  logic [SW-1:0] s_q, s_nx;
  logic [AW-1:0] c_q, c_nx;
  logic [DW-1:0] d_q, d_nx;
  logic          issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      s_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
    end else begin
      state <= state_nx;
      s_q   <= s_nx;
      c_q   <= c_nx;
      d_q   <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s_q;
    c_nx     = c_q;
    d_nx     = d_q;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_READ;
          s_nx     = '0;
          c_nx     = '0;
          d_nx     = '0;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (!hold) begin
          issue = 1'b1;
          if (c_q == C_LAST) begin
            state_nx = ST_DRAIN;
            c_nx     = '0;
          end else begin
            c_nx = c_q + 1'b1;
          end
        end
      end
      // Drain lets the last writes of a stage land before the next stage reads.
      ST_DRAIN: begin
        busy = 1'b1;
        if (d_q == D_LAST) begin
          d_nx = '0;
          if (s_q == S_LAST) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_READ;
            s_nx     = s_q + 1'b1;
          end
        end else begin
          d_nx = d_q + 1'b1;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
        s_nx     = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  logic [KW-1:0]    k0, k1, lo_mask;
  logic [LOG_N-1:0] t_val, t_m1, pow_s, tw0, tw1;
  logic [LOG_N-1:0] idx [4];

  // u(k) inserts a zero at bit log2(t) of k; v(k) sets that bit.
  always_comb begin
    k0      = {c_q, 1'b0};
    k1      = {c_q, 1'b1};
    t_val   = LOG_N'(1) << (S_LAST - s_q);
    t_m1    = t_val - 1'b1;
    lo_mask = t_m1[KW-1:0];
    idx[ROLE_U0] = {k0 & ~lo_mask, 1'b0} | {1'b0, k0 & lo_mask};
    idx[ROLE_V0] = idx[ROLE_U0] | t_val;
    idx[ROLE_U1] = {k1 & ~lo_mask, 1'b0} | {1'b0, k1 & lo_mask};
    idx[ROLE_V1] = idx[ROLE_U1] | t_val;
    pow_s   = LOG_N'(1) << s_q;
    tw0     = pow_s + ({1'b0, k0} >> (S_LAST - s_q));
    tw1     = pow_s + ({1'b0, k1} >> (S_LAST - s_q));
  end

  logic [1:0]    bank_r [4];
  logic [AW-1:0] addr_r [4];
  logic [AW-1:0] rd_addr_a [4];
  logic [1:0]    sel_a_a [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      bank_r[r] = bank_of(16'(idx[r]));
      addr_r[r] = AW'(addr_of(16'(idx[r])));
    end
  end

  // Each of the four roles lands in a distinct bank, so exactly one match per bank.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_addr_a[b] = '0;
      sel_a_a[b]   = '0;
      for (int r = 0; r < 4; r++) begin
        if (issue && bank_r[r] == 2'(b)) begin
          rd_addr_a[b] = addr_r[r];
          sel_a_a[b]   = 2'(r);
        end
      end
    end
  end

  assign stage     = s_q;
  assign rd_en     = issue;
  assign rd_addr_0 = rd_addr_a[0];
  assign rd_addr_1 = rd_addr_a[1];
  assign rd_addr_2 = rd_addr_a[2];
  assign rd_addr_3 = rd_addr_a[3];
  assign sel_a_0   = sel_a_a[0];
  assign sel_a_1   = sel_a_a[1];
  assign sel_a_2   = sel_a_a[2];
  assign sel_a_3   = sel_a_a[3];
  assign tw_idx_0  = issue ? tw0 : '0;
  assign tw_idx_1  = issue ? tw1 : '0;

  logic [PW-1:0] wb_in, wb_out;

  // Write-back is the read issue replayed BF_LAT cycles later (in-place update).
  assign wb_in = {issue, rd_addr_a[3], rd_addr_a[2], rd_addr_a[1], rd_addr_a[0],
                  sel_a_a[3], sel_a_a[2], sel_a_a[1], sel_a_a[0]};

  sub_delay_line #(
    .WIDTH (PW),
    .DEPTH (BF_LAT)
  ) u_wb_delay (
    .clk  (clk),
    .clr  (rst),
    .din  (wb_in),
    .dout (wb_out)
  );

  assign {wr_en, wr_addr_3, wr_addr_2, wr_addr_1, wr_addr_0,
          sel_b_3, sel_b_2, sel_b_1, sel_b_0} = wb_out;

endmodule
